// File: rtl/sha1_padder.sv
// SHA-1 message padder: packs a byte stream into big-endian 32-bit words and
// appends the 0x80 terminator, zero fill and 64-bit bit length per 512-bit block.
module sha1_padder (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] message_size,
    input  logic [31:0] padding_length,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        w_valid,
    output logic [31:0] w_data,
    input  logic        w_ready,
    output logic        w_block_end,
    output logic        w_last,
    output logic        busy,
    output logic        done,
    output logic        err
);
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;

    logic [1:0]  r_state;
    logic [31:0] r_s;
    logic [31:0] r_plen;
    logic [31:0] r_p;
    logic [23:0] r_acc;
    logic        r_w_valid;
    logic [31:0] r_w_data;
    logic        r_block_end;
    logic        r_last;
    logic        r_done;
    logic        r_err;

    logic [32:0] w_min_len;
    logic [32:0] w_max_len;
    logic        w_cfg_ok;
    logic        w_in_msg;
    logic        w_is_term;
    logic        w_in_zero;
    logic        w_completes;
    logic        w_stall;
    logic        w_avail;
    logic        w_gen;
    logic        w_final;
    logic        w_out_hs;
    logic [63:0] w_len;
    logic [7:0]  w_len_byte;
    logic [7:0]  w_byte;

    // 33-bit bounds so a message size near 2^32 cannot wrap into acceptance
    assign w_min_len = {1'b0, message_size} + 33'd9;
    assign w_max_len = {1'b0, message_size} + 33'd72;
    assign w_cfg_ok  = (padding_length[5:0] == 6'd0)
                    && ({1'b0, padding_length} >= w_min_len)
                    && ({1'b0, padding_length} <= w_max_len);

    assign w_in_msg    = (r_p < r_s);
    assign w_is_term   = (r_p == r_s);
    assign w_in_zero   = (r_p < (r_plen - 32'd8));
    assign w_completes = (r_p[1:0] == 2'd3);
    assign w_stall     = w_completes && r_w_valid && !w_ready;
    assign w_avail     = w_in_msg ? in_valid : 1'b1;
    assign w_gen       = (r_state == ST_RUN) && !w_stall && w_avail;
    assign w_final     = (r_p == (r_plen - 32'd1));
    assign w_out_hs    = r_w_valid && w_ready;
    assign w_len       = {29'd0, r_s, 3'd0};

    // Length field starts at P-8, a multiple of 8, so p[2:0] is the byte index
    always_comb begin
        w_len_byte = 8'h00;
        case (r_p[2:0])
            3'd0:    w_len_byte = w_len[63:56];
            3'd1:    w_len_byte = w_len[55:48];
            3'd2:    w_len_byte = w_len[47:40];
            3'd3:    w_len_byte = w_len[39:32];
            3'd4:    w_len_byte = w_len[31:24];
            3'd5:    w_len_byte = w_len[23:16];
            3'd6:    w_len_byte = w_len[15:8];
            3'd7:    w_len_byte = w_len[7:0];
            default: w_len_byte = 8'h00;
        endcase
    end

    // Source of the byte at position p
    always_comb begin
        w_byte = 8'h00;
        if (w_in_msg) begin
            w_byte = in_data;
        end else if (w_is_term) begin
            w_byte = 8'h80;
        end else if (w_in_zero) begin
            w_byte = 8'h00;
        end else begin
            w_byte = w_len_byte;
        end
    end

    // Control state, byte counter, accumulator and output word register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_s         <= 32'd0;
            r_plen      <= 32'd0;
            r_p         <= 32'd0;
            r_acc       <= 24'd0;
            r_w_valid   <= 1'b0;
            r_w_data    <= 32'd0;
            r_block_end <= 1'b0;
            r_last      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            if (w_out_hs) begin
                r_w_valid   <= 1'b0;
                r_block_end <= 1'b0;
                r_last      <= 1'b0;
            end
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        if (w_cfg_ok) begin
                            r_s     <= message_size;
                            r_plen  <= padding_length;
                            r_p     <= 32'd0;
                            r_acc   <= 24'd0;
                            r_state <= ST_RUN;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (w_gen) begin
                        r_p <= r_p + 32'd1;
                        if (w_completes) begin
                            r_w_data    <= {r_acc, w_byte};
                            r_w_valid   <= 1'b1;
                            r_block_end <= (r_p[5:2] == 4'd15);
                            r_last      <= w_final;
                        end else begin
                            r_acc <= {r_acc[15:0], w_byte};
                        end
                        if (w_final) begin
                            r_state <= ST_FLUSH;
                        end
                    end
                end
                ST_FLUSH: begin
                    if (w_out_hs) begin
                        r_done  <= 1'b1;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready    = (r_state == ST_RUN) && w_in_msg && !w_stall;
    assign w_valid     = r_w_valid;
    assign w_data      = r_w_data;
    assign w_block_end = r_block_end;
    assign w_last      = r_last;
    assign busy        = (r_state != ST_IDLE);
    assign done        = r_done;
    assign err         = r_err;

endmodule
